dpu_pipe: RTL and testbench

Parametrised, clocked successor of the data processing unit in the CCU. It holds a register file with configurable width and depth, and runs a two-stage pipeline: operand read, then execute/writeback. Operations arrive over a valid/ready handshake and cover ALU ops, memory load and compare. It also emits a video packet (X, Y, colour registers) on request over its own valid/ready handshake. It sits between the CCU sequencer (op issue, `m_data` source) and the video output path.

---
 rtl/dpu_pkg.sv | 46 ++++
 rtl/dpu_alu.sv | 80 ++++++++
 rtl/dpu_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_dpu_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dpu_pkg
// Brief    : Shared opcode encoding, condition-code bit positions and opcode
//            classification helpers for the data processing unit pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package dpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_LOAD = 4'd8,
        OP_MOV  = 4'd9,
        OP_CMP  = 4'd10,
        OP_INC  = 4'd11,
        OP_DEC  = 4'd12,
        OP_NOP0 = 4'd13,
        OP_NOP1 = 4'd14,
        OP_NOP2 = 4'd15
    } opcode_t;

    // Bit positions inside the {N,Z,C,V} condition-code vector
    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_C = 1;
    localparam int CC_V = 0;

    // NOP encodings leave both the register file and the condition codes alone
    function automatic logic op_is_nop(input opcode_t op);
        return (op == OP_NOP0) || (op == OP_NOP1) || (op == OP_NOP2);
    endfunction

    // CMP only produces flags; everything else except NOP retires a result
    function automatic logic op_writes(input opcode_t op);
        return !op_is_nop(op) && (op != OP_CMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpu_alu.sv
`default_nettype none
// ============================================================================
// Module   : dpu_alu
// Brief    : Combinational execute unit: result and {N,Z,C,V} flags for one
//            operation. Carry/borrow is taken from bit DATA_W of a widened
//            add/subtract.
// Revision : 1.0 - initial release
// ============================================================================
module dpu_alu
    import dpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_m_data,
    input  opcode_t           i_op,
    output logic [DATA_W-1:0] o_result,
    output logic [3:0]        o_flags
);

    localparam int c_msb = DATA_W - 1;

    logic [DATA_W:0] w_ext;
    logic            w_c;
    logic            w_v;

    // Select the operation, derive carry/overflow, then the common N/Z flags
    always_comb begin
        w_ext    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        o_result = '0;
        o_flags  = '0;
        case (i_op)
            OP_ADD: begin
                w_ext = {1'b0, i_a} + {1'b0, i_b};
                w_c   = w_ext[DATA_W];
                w_v   = (i_a[c_msb] == i_b[c_msb]) && (w_ext[c_msb] != i_a[c_msb]);
            end
            OP_SUB, OP_CMP: begin
                w_ext = {1'b0, i_a} - {1'b0, i_b};
                w_c   = w_ext[DATA_W];
                w_v   = (i_a[c_msb] != i_b[c_msb]) && (w_ext[c_msb] != i_a[c_msb]);
            end
            OP_INC: begin
                w_ext = {1'b0, i_a} + (DATA_W+1)'(1);
                w_c   = w_ext[DATA_W];
                w_v   = !i_a[c_msb] && w_ext[c_msb];
            end
            OP_DEC: begin
                w_ext = {1'b0, i_a} - (DATA_W+1)'(1);
                w_c   = w_ext[DATA_W];
                w_v   = i_a[c_msb] && !w_ext[c_msb];
            end
            OP_AND:  w_ext = {1'b0, i_a & i_b};
            OP_OR:   w_ext = {1'b0, i_a | i_b};
            OP_XOR:  w_ext = {1'b0, i_a ^ i_b};
            OP_NOT:  w_ext = {1'b0, ~i_a};
            OP_SHL: begin
                w_ext = {1'b0, i_a[c_msb-1:0], 1'b0};
                w_c   = i_a[c_msb];
            end
            OP_SHR: begin
                w_ext = {2'b00, i_a[c_msb:1]};
                w_c   = i_a[0];
            end
            OP_LOAD: w_ext = {1'b0, i_m_data};
            OP_MOV:  w_ext = {1'b0, i_a};
            default: w_ext = '0;
        endcase
        o_result       = w_ext[DATA_W-1:0];
        o_flags[CC_N]  = o_result[c_msb];
        o_flags[CC_Z]  = (o_result == '0);
        o_flags[CC_C]  = w_c;
        o_flags[CC_V]  = w_v;
    end

endmodule
`default_nettype wire

// File: rtl/dpu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dpu_pipe
// Brief    : Two-stage data processing unit: operand read with result
//            forwarding, then execute/writeback. Also snapshots the X/Y/colour
//            registers into a held video packet on request.
// Revision : 1.0 - initial release
// ============================================================================
module dpu_pipe
    import dpu_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int REG_DEPTH = 16,
    parameter  int X_REG     = 9,
    parameter  int Y_REG     = 10,
    parameter  int C_REG     = 11,
    parameter  int ONE_REG   = 12,
    localparam int ADDR_W    = $clog2(REG_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [ADDR_W-1:0] a_sel,
    input  logic [ADDR_W-1:0] b_sel,
    input  logic [ADDR_W-1:0] r_sel,
    input  logic [DATA_W-1:0] m_data,
    output logic [3:0]        cc,
    output logic              busy,
    input  logic              vid_req,
    output logic              vid_valid,
    input  logic              vid_ready,
    output logic [DATA_W-1:0] vid_x,
    output logic [DATA_W-1:0] vid_y,
    output logic [DATA_W-1:0] vid_colour,
    output logic              vid_overrun
);

    // Widened so the range check also works when REG_DEPTH == 2**ADDR_W
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(REG_DEPTH);
    localparam logic [ADDR_W-1:0] c_x_sel = ADDR_W'(X_REG);
    localparam logic [ADDR_W-1:0] c_y_sel = ADDR_W'(Y_REG);
    localparam logic [ADDR_W-1:0] c_c_sel = ADDR_W'(C_REG);

    typedef enum logic [0:0] {
        VID_IDLE = 1'b0,
        VID_HOLD = 1'b1
    } vid_state_t;

    logic [DATA_W-1:0] r_regs [REG_DEPTH];

    logic              r_s2_valid;
    opcode_t           r_s2_op;
    logic [ADDR_W-1:0] r_s2_rsel;
    logic [DATA_W-1:0] r_s2_a;
    logic [DATA_W-1:0] r_s2_b;
    logic [DATA_W-1:0] r_s2_mdata;
    logic [3:0]        r_cc;

    logic [DATA_W-1:0] w_result;
    logic [3:0]        w_flags;
    logic              w_wr_en;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_rd_x;
    logic [DATA_W-1:0] w_rd_y;
    logic [DATA_W-1:0] w_rd_c;

    vid_state_t        r_vid_state;
    vid_state_t        w_vid_next;
    logic              w_capture;
    logic              w_overrun_set;
    logic [DATA_W-1:0] r_vid_x;
    logic [DATA_W-1:0] r_vid_y;
    logic [DATA_W-1:0] r_vid_c;
    logic              r_vid_overrun;

    // Selects beyond the populated depth read as zero and never write
    function automatic logic f_in_range(input logic [ADDR_W-1:0] sel);
        return {1'b0, sel} < c_depth;
    endfunction

    // Register read with bypass of the result retiring this cycle
    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] sel,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wsel,
        input logic [DATA_W-1:0] wdata
    );
        if (!f_in_range(sel))
            return '0;
        else if (we && (sel == wsel))
            return wdata;
        else
            return stored;
    endfunction

    dpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (r_s2_a),
        .i_b      (r_s2_b),
        .i_m_data (r_s2_mdata),
        .i_op     (r_s2_op),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    assign op_ready = !rst;
    assign w_accept = op_valid && op_ready;
    assign w_wr_en  = r_s2_valid && op_writes(r_s2_op) && f_in_range(r_s2_rsel);

    // Forwarded operand and video-source reads
    always_comb begin
        w_rd_a = f_read(a_sel,   r_regs[a_sel],   w_wr_en, r_s2_rsel, w_result);
        w_rd_b = f_read(b_sel,   r_regs[b_sel],   w_wr_en, r_s2_rsel, w_result);
        w_rd_x = f_read(c_x_sel, r_regs[c_x_sel], w_wr_en, r_s2_rsel, w_result);
        w_rd_y = f_read(c_y_sel, r_regs[c_y_sel], w_wr_en, r_s2_rsel, w_result);
        w_rd_c = f_read(c_c_sel, r_regs[c_c_sel], w_wr_en, r_s2_rsel, w_result);
    end

    // Register file: reset image has only ONE_REG set, writeback from stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++)
                r_regs[i] <= (i == ONE_REG) ? DATA_W'(1) : '0;
        end else if (w_wr_en) begin
            r_regs[r_s2_rsel] <= w_result;
        end
    end

    // Stage 1 -> stage 2 pipeline register; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_op    <= OP_NOP0;
            r_s2_rsel  <= '0;
            r_s2_a     <= '0;
            r_s2_b     <= '0;
            r_s2_mdata <= '0;
        end else begin
            r_s2_valid <= w_accept;
            if (w_accept) begin
                r_s2_op    <= opcode_t'(op_code);
                r_s2_rsel  <= r_sel;
                r_s2_a     <= w_rd_a;
                r_s2_b     <= w_rd_b;
                r_s2_mdata <= m_data;
            end
        end
    end

    // Condition codes follow every executed op except NOP
    always_ff @(posedge clk) begin
        if (rst)
            r_cc <= '0;
        else if (r_s2_valid && !op_is_nop(r_s2_op))
            r_cc <= w_flags;
    end

    // Video handshake state register
    always_ff @(posedge clk) begin
        if (rst)
            r_vid_state <= VID_IDLE;
        else
            r_vid_state <= w_vid_next;
    end

    // Video next state: a request in the completing cycle re-captures cleanly
    always_comb begin
        w_vid_next    = r_vid_state;
        w_capture     = 1'b0;
        w_overrun_set = 1'b0;
        case (r_vid_state)
            VID_IDLE: begin
                if (vid_req) begin
                    w_capture  = 1'b1;
                    w_vid_next = VID_HOLD;
                end
            end
            VID_HOLD: begin
                if (vid_ready) begin
                    w_capture  = vid_req;
                    w_vid_next = vid_req ? VID_HOLD : VID_IDLE;
                end else if (vid_req) begin
                    w_overrun_set = 1'b1;
                end
            end
            default: w_vid_next = VID_IDLE;
        endcase
    end

    // Snapshot payload and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vid_x       <= '0;
            r_vid_y       <= '0;
            r_vid_c       <= '0;
            r_vid_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_vid_x <= w_rd_x;
                r_vid_y <= w_rd_y;
                r_vid_c <= w_rd_c;
            end
            if (w_overrun_set)
                r_vid_overrun <= 1'b1;
        end
    end

    assign cc          = r_cc;
    assign busy        = r_s2_valid;
    assign vid_valid   = (r_vid_state == VID_HOLD);
    assign vid_x       = r_vid_x;
    assign vid_y       = r_vid_y;
    assign vid_colour  = r_vid_c;
    assign vid_overrun = r_vid_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dpu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpu_pipe
// Brief    : Self-checking bench for dpu_pipe (8x16 and 16x32 instances)
//            against an arithmetic reference model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpu_pipe;

    localparam int ADD = 0, SUB = 1, SHL = 6, LOAD = 8, MOV = 9, CMP = 10, NOP = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_ready, busy;
    logic [3:0]  op_code, a_sel, b_sel, r_sel, cc;
    logic [7:0]  m_data, vid_x, vid_y, vid_colour;
    logic        vid_req, vid_valid, vid_ready, vid_overrun;

    logic        b_op_valid, b_op_ready, b_busy;
    logic [3:0]  b_op_code, b_cc;
    logic [4:0]  b_a_sel, b_b_sel, b_r_sel;
    logic [15:0] b_m_data, b_vid_x, b_vid_y, b_vid_colour;
    logic        b_vid_req, b_vid_valid, b_vid_ready, b_vid_overrun;

    int          total = 0;
    int          bad   = 0;
    int          m [16];
    logic [3:0]  mcc;
    bit          vid_auto;
    bit          exp_ovr;

    always #5 clk = ~clk;

    dpu_pipe u_dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .a_sel(a_sel), .b_sel(b_sel), .r_sel(r_sel),
        .m_data(m_data), .cc(cc), .busy(busy), .vid_req(vid_req),
        .vid_valid(vid_valid), .vid_ready(vid_ready), .vid_x(vid_x),
        .vid_y(vid_y), .vid_colour(vid_colour), .vid_overrun(vid_overrun)
    );

    dpu_pipe #(.DATA_W(16), .REG_DEPTH(32)) u_dut16 (
        .clk(clk), .rst(rst), .op_valid(b_op_valid), .op_ready(b_op_ready),
        .op_code(b_op_code), .a_sel(b_a_sel), .b_sel(b_b_sel), .r_sel(b_r_sel),
        .m_data(b_m_data), .cc(b_cc), .busy(b_busy), .vid_req(b_vid_req),
        .vid_valid(b_vid_valid), .vid_ready(b_vid_ready), .vid_x(b_vid_x),
        .vid_y(b_vid_y), .vid_colour(b_vid_colour), .vid_overrun(b_vid_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i] = 0;
        m[12] = 1;
        mcc   = 4'b0000;
    endtask

    // Reference semantics in plain integer arithmetic on 8-bit values
    task automatic model_op(input int op, input int a, input int b, input int r, input int md);
        int av, bv, sa, sb, full, res;
        bit c, v;
        av = m[a]; bv = m[b];
        sa = (av >= 128) ? av - 256 : av;
        sb = (bv >= 128) ? bv - 256 : bv;
        c = 1'b0; v = 1'b0; full = 0;
        case (op)
            0:     begin full = av + bv; c = (full > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            1, 10: begin full = av - bv; c = (av < bv);   v = (sa - sb > 127) || (sa - sb < -128); end
            2:     full = av & bv;
            3:     full = av | bv;
            4:     full = av ^ bv;
            5:     full = 255 - av;
            6:     begin full = av * 2; c = (av >= 128); end
            7:     begin full = av / 2; c = (av % 2 == 1); end
            8:     full = md & 255;
            9:     full = av;
            11:    begin full = av + 1; c = (av == 255); v = (sa == 127); end
            12:    begin full = av - 1; c = (av == 0);   v = (sa == -128); end
            default: return;
        endcase
        res = full & 255;
        mcc = {res >= 128, res == 0, c, v};
        if (op != 10) m[r] = res;
    endtask

    // One clock step on the 8-bit instance; checks results retiring at this edge
    task automatic do_op(input int op, input int a, input int b, input int r,
                         input int md, input bit vld, input bit vreq);
        logic [3:0] e_cc;
        int ex, ey, ec;
        e_cc = mcc; ex = m[9]; ey = m[10]; ec = m[11];
        op_valid = vld; op_code = 4'(op); a_sel = 4'(a); b_sel = 4'(b);
        r_sel = 4'(r); m_data = 8'(md); vid_req = vreq;
        if (vld) model_op(op, a, b, r, md);
        @(posedge clk); #1;
        op_valid = 1'b0; vid_req = 1'b0;
        check("cc", 32'(cc), 32'(e_cc));
        check("busy", 32'(busy), 32'(vld));
        if (vid_auto) begin
            check("vid_valid", 32'(vid_valid), 32'(vreq));
            if (vreq) begin
                check("vid_x", 32'(vid_x), 32'(ex));
                check("vid_y", 32'(vid_y), 32'(ey));
                check("vid_colour", 32'(vid_colour), 32'(ec));
            end
            check("vid_overrun", 32'(vid_overrun), 32'(exp_ovr));
        end
    endtask

    task automatic readreg(input int r, input int exp);
        do_op(MOV, r, 0, 9, 0, 1'b1, 1'b0);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b1);
        check($sformatf("reg%0d", r), 32'(vid_x), 32'(exp));
    endtask

    task automatic do16(input int op, input int a, input int b, input int r,
                        input logic [15:0] md, input bit vld, input bit vreq);
        b_op_valid = vld; b_op_code = 4'(op); b_a_sel = 5'(a); b_b_sel = 5'(b);
        b_r_sel = 5'(r); b_m_data = md; b_vid_req = vreq;
        @(posedge clk); #1;
        b_op_valid = 1'b0; b_vid_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        op_valid = 1'b0; op_code = '0; a_sel = '0; b_sel = '0; r_sel = '0; m_data = '0;
        vid_req = 1'b0; vid_ready = 1'b1;
        b_op_valid = 1'b0; b_op_code = '0; b_a_sel = '0; b_b_sel = '0; b_r_sel = '0;
        b_m_data = '0; b_vid_req = 1'b0; b_vid_ready = 1'b1;
        vid_auto = 1'b1; exp_ovr = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_cc", 32'(cc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vid_valid", 32'(vid_valid), 32'd0);
        check("rst_overrun", 32'(vid_overrun), 32'd0);
        check("rst_vid_x", 32'(vid_x), 32'd0);
        rst = 1'b0;
        #1;
        check("op_ready", 32'(op_ready), 32'd1);
        readreg(12, 1);
        readreg(0, 0);
        readreg(5, 0);

        // Back-to-back dependent ops through the forwarding path
        do_op(LOAD, 0, 0, 1, 'h7F, 1'b1, 1'b0);
        do_op(LOAD, 0, 0, 2, 'h01, 1'b1, 1'b0);
        do_op(ADD, 1, 2, 3, 0, 1'b1, 1'b0);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b0);
        check("add_cc", 32'(cc), 32'b1001);
        readreg(3, 'h80);

        // SUB borrow, CMP without writeback, SHL carry-out
        do_op(LOAD, 0, 0, 5, 'h01, 1'b1, 1'b0);
        do_op(SUB, 0, 5, 6, 0, 1'b1, 1'b0);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b0);
        check("sub_cc", 32'(cc), 32'b1010);
        do_op(CMP, 5, 5, 6, 0, 1'b1, 1'b0);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b0);
        check("cmp_cc", 32'(cc), 32'b0100);
        readreg(6, 'hFF);
        do_op(LOAD, 0, 0, 7, 'h81, 1'b1, 1'b0);
        do_op(SHL, 7, 0, 8, 0, 1'b1, 1'b0);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b0);
        check("shl_cc", 32'(cc), 32'b0010);
        readreg(8, 'h02);

        // Video snapshot capturing a same-cycle writeback
        do_op(LOAD, 0, 0, 9, 3, 1'b1, 1'b0);
        do_op(LOAD, 0, 0, 10, 4, 1'b1, 1'b0);
        do_op(LOAD, 0, 0, 11, 'hAA, 1'b1, 1'b0);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b1);
        check("snap_x", 32'(vid_x), 32'd3);
        check("snap_y", 32'(vid_y), 32'd4);
        check("snap_c", 32'(vid_colour), 32'hAA);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b1);
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b0);

        // Held packet with vid_ready low, then overrun
        vid_ready = 1'b0;
        vid_auto  = 1'b0;
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b1);
        check("hold_valid0", 32'(vid_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            do_op(LOAD, 0, 0, 9, 'h55 + i, 1'b1, i == 2);
            check("hold_valid", 32'(vid_valid), 32'd1);
            check("hold_x", 32'(vid_x), 32'd3);
            check("hold_y", 32'(vid_y), 32'd4);
            check("hold_c", 32'(vid_colour), 32'hAA);
            check("hold_ovr", 32'(vid_overrun), 32'(i >= 2));
        end
        vid_ready = 1'b1;
        do_op(NOP, 0, 0, 0, 0, 1'b0, 1'b0);
        check("drain_valid", 32'(vid_valid), 32'd0);
        check("drain_ovr", 32'(vid_overrun), 32'd1);
        exp_ovr  = 1'b1;
        vid_auto = 1'b1;

        // Randomised traffic against the model
        for (int i = 0; i < 200; i++) begin
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0);
        end
        for (int r = 0; r < 16; r++) begin
            int e;
            e = m[r];
            readreg(r, e);
        end

        // Reset while a LOAD sits in stage 2
        do_op(LOAD, 0, 0, 4, 'h5A, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_op_ready", 32'(op_ready), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_cc", 32'(cc), 32'd0);
        check("mid_ovr", 32'(vid_overrun), 32'd0);
        check("mid_vid_valid", 32'(vid_valid), 32'd0);
        rst = 1'b0;
        model_reset();
        exp_ovr = 1'b0;
        readreg(4, 0);
        readreg(12, 1);

        // 16-bit, 32-deep instance
        do16(LOAD, 0, 0, 1, 16'hFFFF, 1'b1, 1'b0);
        do16(LOAD, 0, 0, 2, 16'h0001, 1'b1, 1'b0);
        do16(ADD, 1, 2, 3, 16'h0, 1'b1, 1'b0);
        do16(NOP, 0, 0, 0, 16'h0, 1'b0, 1'b0);
        check("w16_add_cc", 32'(b_cc), 32'b0110);
        do16(LOAD, 0, 0, 31, 16'hBEEF, 1'b1, 1'b0);
        do16(MOV, 31, 0, 9, 16'h0, 1'b1, 1'b0);
        do16(MOV, 3, 0, 10, 16'h0, 1'b1, 1'b0);
        do16(NOP, 0, 0, 0, 16'h0, 1'b0, 1'b1);
        check("w16_vid_valid", 32'(b_vid_valid), 32'd1);
        check("w16_r31", 32'(b_vid_x), 32'hBEEF);
        check("w16_r3", 32'(b_vid_y), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
